input_port: RTL and testbench

INPUT_PORT -- requirements
Module: input_port

---
 rtl/input_port_if.sv | 16 +
 rtl/input_port.sv | 160 ++++++++++++++++
 tb/tb_input_port.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_port_if.sv
// CPU-side read handshake for the switch input port: level request, pulsed ack,
// plus buffer status flags.
`timescale 1ns/1ps

interface input_port_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  rd_req;
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  overrun;

  modport master (output rd_req, input rd_ack, rd_data, full, overrun);
  modport slave  (input rd_req, output rd_ack, rd_data, full, overrun);
endinterface

// File: rtl/input_port.sv
// Switch input port: synchronizes switches and the enter button, debounces the button,
// captures the switches on each press and hands the value to the CPU via a one-entry buffer.
`timescale 1ns/1ps

module input_port #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_WIDTH   = 4,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_WIDTH-1:0] sw,
  input  logic                btn_enter,
  input_port_if.slave         bus
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  logic [IN_WIDTH-1:0]   sw_meta_r;
  logic [IN_WIDTH-1:0]   sw_s_r;
  logic                  btn_meta_r;
  logic                  btn_s_r;
  logic                  btn_db_r;
  logic                  btn_db_d_r;
  logic [CNT_W-1:0]      cnt_r;
  state_t                state_r;
  logic [DATA_WIDTH-1:0] buf_r;
  logic                  rd_ack_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  full_r;
  logic                  overrun_r;

  logic                  press_s;
  logic [DATA_WIDTH-1:0] cap_val_s;

  // Two-flop synchronizers for the asynchronous switch and button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_r  <= '0;
      sw_s_r     <= '0;
      btn_meta_r <= 1'b0;
      btn_s_r    <= 1'b0;
    end else begin
      sw_meta_r  <= sw;
      sw_s_r     <= sw_meta_r;
      btn_meta_r <= btn_enter;
      btn_s_r    <= btn_meta_r;
    end
  end

  // Debounce: the synchronized button must differ from btn_db for DEB_CYCLES edges in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      btn_db_r   <= 1'b0;
      btn_db_d_r <= 1'b0;
    end else begin
      btn_db_d_r <= btn_db_r;
      if (btn_s_r == btn_db_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        cnt_r    <= '0;
        btn_db_r <= btn_s_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Press lasts exactly the one cycle after btn_db rises; release is ignored
  assign press_s   = btn_db_r & ~btn_db_d_r;
  assign cap_val_s = DATA_WIDTH'(sw_s_r);

  // Buffer / read-handshake FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_EMPTY;
      buf_r     <= '0;
      rd_ack_r  <= 1'b0;
      rd_data_r <= '0;
      full_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      rd_ack_r <= 1'b0;
      full_r   <= 1'b0;
      case (state_r)
        ST_EMPTY: begin
          if (press_s) begin
            state_r <= ST_FULL;
            buf_r   <= cap_val_s;
            full_r  <= 1'b1;
          end else if (bus.rd_req) begin
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (bus.rd_req) begin
            state_r   <= ST_ACK;
            rd_ack_r  <= 1'b1;
            // A press racing the read wins: the CPU gets the newest value
            rd_data_r <= press_s ? cap_val_s : buf_r;
            if (press_s) begin
              overrun_r <= 1'b1;
            end
          end else if (press_s) begin
            state_r   <= ST_FULL;
            buf_r     <= cap_val_s;
            overrun_r <= 1'b1;
            full_r    <= 1'b1;
          end else begin
            state_r <= ST_FULL;
            full_r  <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (press_s) begin
            state_r   <= ST_ACK;
            rd_ack_r  <= 1'b1;
            rd_data_r <= cap_val_s;
          end else if (!bus.rd_req) begin
            state_r <= ST_EMPTY;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_ACK: begin
          // rd_req is ignored here; the buffer was just drained so overrun is retired
          overrun_r <= 1'b0;
          if (press_s) begin
            state_r <= ST_FULL;
            buf_r   <= cap_val_s;
            full_r  <= 1'b1;
          end else begin
            state_r <= ST_EMPTY;
          end
        end
        default: begin
          state_r   <= ST_EMPTY;
          overrun_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_ack  = rd_ack_r;
  assign bus.rd_data = rd_data_r;
  assign bus.full    = full_r;
  assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_input_port.sv
// Bench for input_port: directed scenarios plus random button/read traffic, every cycle
// compared against a window-based debounce and buffer-occupancy reference model.
`timescale 1ns/1ps

module tb_input_port;

  localparam int DW  = 16;
  localparam int IW  = 4;
  localparam int DEB = 4;

  logic          clk;
  logic          rst_n;
  logic [IW-1:0] sw;
  logic          btn_enter;

  input_port_if #(.DATA_WIDTH(DW)) if_u ();

  input_port #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .DEB_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .btn_enter(btn_enter),
    .bus      (if_u.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;
  logic [DW-1:0] last_ack_data = '0;

  // Reference model state
  logic [IW-1:0] m_sw_m, m_sw_s;
  bit            m_btn_m, m_btn_s, m_db, m_db_prev;
  bit            hist[$];
  bit            m_full, m_wait, m_ack, m_ovr;
  logic [DW-1:0] m_buf, m_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sw_m = '0; m_sw_s = '0;
    m_btn_m = 0; m_btn_s = 0; m_db = 0; m_db_prev = 0;
    hist.delete();
    m_full = 0; m_wait = 0; m_ack = 0; m_ovr = 0;
    m_buf = '0; m_data = '0;
  endtask

  // One rising edge of the reference, using the inputs present before the edge
  task automatic model_edge(input bit req, input bit btn, input logic [IW-1:0] s);
    bit ev;
    bit all_diff;
    logic [DW-1:0] val;
    ev  = m_db && !m_db_prev;
    val = DW'(m_sw_s);
    if (m_ack) begin
      m_ack = 0; m_ovr = 0;
      if (ev) begin m_full = 1; m_buf = val; end
    end else if (m_full) begin
      if (req) begin
        m_full = 0; m_ack = 1; m_data = ev ? val : m_buf;
        if (ev) m_ovr = 1;
      end else if (ev) begin
        m_buf = val; m_ovr = 1;
      end
    end else if (m_wait) begin
      if (ev) begin m_wait = 0; m_ack = 1; m_data = val; end
      else if (!req) m_wait = 0;
    end else begin
      if (ev) begin m_full = 1; m_buf = val; end
      else if (req) m_wait = 1;
    end
    // Debounced level flips once the last DEB synchronized samples all disagree with it
    m_db_prev = m_db;
    hist.push_back(m_btn_s);
    if (hist.size() > DEB) void'(hist.pop_front());
    all_diff = (hist.size() == DEB);
    foreach (hist[i]) all_diff &= (hist[i] != m_db);
    if (all_diff) begin
      m_db = !m_db;
      hist.delete();
    end
    m_btn_s = m_btn_m; m_btn_m = btn;
    m_sw_s  = m_sw_m;  m_sw_m  = s;
  endtask

  task automatic step();
    bit r, b;
    logic [IW-1:0] s;
    r = if_u.rd_req; b = btn_enter; s = sw;
    @(posedge clk);
    model_edge(r, b, s);
    #1;
    check_eq("ack",  32'(if_u.rd_ack),  32'(m_ack));
    check_eq("full", 32'(if_u.full),    32'(m_full));
    check_eq("data", 32'(if_u.rd_data), 32'(m_data));
    check_eq("ovr",  32'(if_u.overrun), 32'(m_ovr));
    if (if_u.rd_ack === 1'b1) begin
      ack_cnt++;
      last_ack_data = if_u.rd_data;
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ack"},  32'(if_u.rd_ack),  32'd0);
    check_eq({tag, "_data"}, 32'(if_u.rd_data), 32'd0);
    check_eq({tag, "_full"}, 32'(if_u.full),    32'd0);
    check_eq({tag, "_ovr"},  32'(if_u.overrun), 32'd0);
  endtask

  // Assert reset mid-cycle, check outputs clear at once, release mid-cycle
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    check_zero({tag, "_hold"});
    #3;
    rst_n = 1'b1;
    ack_cnt = 0;
  endtask

  task automatic press(input logic [IW-1:0] v, input int hold);
    sw = v;
    btn_enter = 1'b1;
    repeat (hold) step();
    btn_enter = 1'b0;
    repeat (DEB + 4) step();
  endtask

  task automatic read_once();
    if_u.rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (if_u.rd_ack === 1'b1) if_u.rd_req = 1'b0;
    end
    if_u.rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int run_left;
    rst_n = 1'b0; sw = '0; btn_enter = 1'b0; if_u.rd_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("por");

    // Basic press latency and read
    do_reset("r030");
    sw = 4'hA; btn_enter = 1'b1;
    repeat (6) step();
    check_eq("r030_not_yet", 32'(if_u.full), 32'd0);
    step();
    check_eq("r030_full", 32'(if_u.full), 32'd1);
    if_u.rd_req = 1'b1;
    step();
    check_eq("r030_ack",  32'(if_u.rd_ack),  32'd1);
    check_eq("r030_data", 32'(if_u.rd_data), 32'h000A);
    if_u.rd_req = 1'b0;
    step();
    check_eq("r030_drained", 32'(if_u.full), 32'd0);
    btn_enter = 1'b0;
    repeat (DEB + 4) step();

    // Bouncing button never settles
    do_reset("r031");
    repeat (10) begin
      btn_enter = 1'b1; repeat (3) step();
      btn_enter = 1'b0; step();
    end
    repeat (DEB + 4) step();
    check_eq("r031_full", 32'(if_u.full), 32'd0);
    check_eq("r031_acks", 32'(ack_cnt), 32'd0);

    // CPU waits, then a press is delivered straight through
    do_reset("r032");
    if_u.rd_req = 1'b1;
    repeat (20) step();
    sw = 4'h5; btn_enter = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (if_u.rd_ack === 1'b1) if_u.rd_req = 1'b0;
    end
    btn_enter = 1'b0;
    repeat (DEB + 4) step();
    check_eq("r032_acks", 32'(ack_cnt), 32'd1);
    check_eq("r032_data", 32'(last_ack_data), 32'h0005);
    check_eq("r032_ovr",  32'(if_u.overrun), 32'd0);

    // Overwrite before read
    do_reset("r033");
    press(4'h3, DEB + 4);
    press(4'h9, DEB + 4);
    check_eq("r033_ovr_set", 32'(if_u.overrun), 32'd1);
    if_u.rd_req = 1'b1;
    step();
    check_eq("r033_ack",  32'(if_u.rd_ack),  32'd1);
    check_eq("r033_data", 32'(if_u.rd_data), 32'h0009);
    check_eq("r033_ovr_ack", 32'(if_u.overrun), 32'd1);
    if_u.rd_req = 1'b0;
    step();
    check_eq("r033_ovr_clr", 32'(if_u.overrun), 32'd0);

    // Reset in WAIT and in FULL
    do_reset("r034a");
    if_u.rd_req = 1'b1;
    repeat (3) step();
    do_reset("r034_wait");
    repeat (12) step();
    check_eq("r034_wait_noack", 32'(ack_cnt), 32'd0);
    if_u.rd_req = 1'b0;
    step();
    press(4'h2, DEB + 4);
    do_reset("r034_full");
    if_u.rd_req = 1'b1;
    repeat (12) step();
    check_eq("r034_full_noack", 32'(ack_cnt), 32'd0);
    if_u.rd_req = 1'b0;
    step();

    // Press lands in the ACK cycle
    do_reset("r035");
    press(4'h1, DEB + 4);
    sw = 4'h2; btn_enter = 1'b1;
    repeat (5) step();
    if_u.rd_req = 1'b1;
    step();
    check_eq("r035_ack1",  32'(if_u.rd_ack),  32'd1);
    check_eq("r035_data1", 32'(if_u.rd_data), 32'h0001);
    if_u.rd_req = 1'b0;
    step();
    check_eq("r035_refill", 32'(if_u.full), 32'd1);
    read_once();
    check_eq("r035_data2", 32'(last_ack_data), 32'h0002);
    btn_enter = 1'b0;
    repeat (DEB + 4) step();

    // Random traffic against the model
    do_reset("rnd");
    run_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0) begin
        btn_enter = 1'($urandom_range(0, 1));
        run_left  = int'($urandom_range(1, 10));
        sw        = IW'($urandom);
      end
      run_left--;
      if (if_u.rd_req === 1'b0) begin
        if ($urandom_range(0, 7) == 0) if_u.rd_req = 1'b1;
      end else if ($urandom_range(0, 19) == 0) begin
        if_u.rd_req = 1'b0;
      end
      step();
      if (if_u.rd_ack === 1'b1) if_u.rd_req = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
